// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle for the two register-file write-back ports.
// Port 0 is the in-order pipeline; port 1 is the long-latency unit.
interface regfile_wb_arbiter_if;
  logic        wb0_vld;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb0_rdy;
  logic        wb1_vld;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        wb1_rdy;

  modport master (
    output wb0_vld, wb0_rd, wb0_data,
    output wb1_vld, wb1_rd, wb1_data,
    input  wb0_rdy, wb1_rdy
  );

  modport slave (
    input  wb0_vld, wb0_rd, wb0_data,
    input  wb1_vld, wb1_rd, wb1_data,
    output wb0_rdy, wb1_rdy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline (port 0, priority) and
// long-latency write-back (port 1, starvation-guarded); x0 writes are dropped.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  wb,
  output logic                 RegWrite,
  output logic [4:0]           WriteRegister,
  output logic [31:0]          WriteData,
  output logic                 fwd_vld,
  output logic [4:0]           fwd_rd,
  output logic [31:0]          fwd_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        req0, req1;
  logic        grant0, grant1;
  logic        acc0, acc1;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        wr_q, wr_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;

  // Only nonzero-rd requests compete; x0 requests are swallowed on sight.
  always_comb begin
    req0   = wb.wb0_vld && (wb.wb0_rd != 5'd0);
    req1   = wb.wb1_vld && (wb.wb1_rd != 5'd0);
    grant1 = req1 && (!req0 || (starve_cnt_q == LIMIT));
    grant0 = req0 && !grant1;
    acc0   = rst_n && wb.wb0_vld && ((wb.wb0_rd == 5'd0) || grant0);
    acc1   = rst_n && wb.wb1_vld && ((wb.wb1_rd == 5'd0) || grant1);
  end

  assign wb.wb0_rdy = acc0;
  assign wb.wb1_rdy = acc1;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!wb.wb1_vld || acc1) begin
      starve_cnt_d = 4'd0;
    end else if (req1 && grant0 && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Address/data hold when idle so the forwarding copy stays stable.
  always_comb begin
    wr_d   = grant0 || grant1;
    rd_d   = rd_q;
    data_d = data_q;
    if (grant0) begin
      rd_d   = wb.wb0_rd;
      data_d = wb.wb0_data;
    end else if (grant1) begin
      rd_d   = wb.wb1_rd;
      data_d = wb.wb1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
      wr_q         <= 1'b0;
      rd_q         <= 5'd0;
      data_q       <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
    end
  end

  assign RegWrite      = wr_q;
  assign WriteRegister = rd_q;
  assign WriteData     = data_q;
  assign fwd_vld       = wr_q;
  assign fwd_rd        = rd_q;
  assign fwd_data      = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: a rule-level arbitration model predicts accepts and queues
// the expected register-file writes; a negedge monitor checks the write port.
module tb_regfile_wb_arbiter;
  localparam int LIMIT = 3;
  localparam bit [7:0] ORDER = 8'b1000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        fwd_vld;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .wb(bus),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .fwd_vld(fwd_vld), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          losses = 0;
  bit          mon_en = 1'b0;
  wr_t         exp_q[$];
  logic [31:0] rf[32] = '{default: 32'd0};
  logic [31:0] exp_rf[32] = '{default: 32'd0};

  always @(posedge clk) cyc <= cyc + 1;

  // Register file fed by the DUT write port.
  always @(posedge clk) if (RegWrite && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;

  task automatic chk(string name, logic [63:0] act, logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // One request cycle: present inputs, predict accepts from the arbitration rules.
  task automatic drive(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                       output bit a0, output bit a1);
    bit q0, q1, w0, w1;
    @(posedge clk); #1;
    bus.wb0_vld = v0; bus.wb0_rd = r0; bus.wb0_data = d0;
    bus.wb1_vld = v1; bus.wb1_rd = r1; bus.wb1_data = d1;
    q0 = v0 && (r0 != 0);
    q1 = v1 && (r1 != 0);
    w1 = q1 && (!q0 || losses == LIMIT);
    w0 = q0 && !w1;
    a0 = v0 && (r0 == 0 || w0);
    a1 = v1 && (r1 == 0 || w1);
    if (!v1 || a1) losses = 0;
    else if (w0 && losses < LIMIT) losses++;
    if (w0) begin exp_q.push_back('{cyc + 1, r0, d0}); exp_rf[r0] = d0; end
    if (w1) begin exp_q.push_back('{cyc + 1, r1, d1}); exp_rf[r1] = d1; end
    #1;
    chk("wb0_rdy", bus.wb0_rdy, a0);
    chk("wb1_rdy", bus.wb1_rdy, a1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        wr_t w;
        w = exp_q.pop_front();
        chk("RegWrite", RegWrite, 1);
        chk("WriteRegister", WriteRegister, w.rd);
        chk("WriteData", WriteData, w.data);
        chk("fwd_vld", fwd_vld, 1);
        chk("fwd_rd", fwd_rd, w.rd);
        chk("fwd_data", fwd_data, w.data);
      end else begin
        chk("RegWrite_idle", RegWrite, 0);
      end
    end
  end

  initial begin
    bit a0, a1, p0, p1;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1, old12;
    int k;

    bus.wb0_vld = 1; bus.wb0_rd = 3; bus.wb0_data = 32'h33;
    bus.wb1_vld = 1; bus.wb1_rd = 4; bus.wb1_data = 32'h44;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_wb0_rdy", bus.wb0_rdy, 0);
    chk("rst_wb1_rdy", bus.wb1_rdy, 0);
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_WriteRegister", WriteRegister, 0);
    chk("rst_WriteData", WriteData, 0);
    chk("rst_fwd_vld", fwd_vld, 0);
    bus.wb0_vld = 0; bus.wb1_vld = 0;
    @(negedge clk); #1;
    rst_n = 1; mon_en = 1;

    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, a0, a1);
    drive(0, 0, 0, 0, 0, 0, a0, a1);
    drive(0, 0, 0, 0, 0, 0, a0, a1);

    // Both ports continuously requesting: port 1 every (LIMIT+1)th cycle.
    k = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 32'h100 + 32'(k), 1, 2, 32'hB0, a0, a1);
      chk("starve_order", bus.wb1_rdy, ORDER[i]);
      if (a0) k++;
    end
    drive(0, 0, 0, 0, 0, 0, a0, a1);

    drive(1, 7, 32'h11, 1, 0, 32'h22, a0, a1);
    drive(1, 0, 32'h5A, 1, 0, 32'hA5, a0, a1);
    drive(1, 9, 32'h1, 1, 9, 32'h2, a0, a1);
    drive(0, 0, 0, 1, 9, 32'h2, a0, a1);
    drive(0, 0, 0, 0, 0, 0, a0, a1);

    p0 = 0; p1 = 0; r0 = 0; r1 = 0; d0 = 0; d1 = 0;
    repeat (400) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1; r0 = 5'($urandom_range(0, 9)); d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; r1 = 5'($urandom_range(0, 9)); d1 = $urandom;
      end
      drive(p0, r0, d0, p1, r1, d1, a0, a1);
      if (a0) p0 = 0;
      if (a1) p1 = 0;
    end
    while (p1 || p0) begin
      drive(p0, r0, d0, p1, r1, d1, a0, a1);
      if (a0) p0 = 0;
      if (a1) p1 = 0;
    end
    drive(0, 0, 0, 0, 0, 0, a0, a1);
    drive(0, 0, 0, 0, 0, 0, a0, a1);

    // Asynchronous reset while a write to x12 is on the port: write is lost.
    old12 = exp_rf[12];
    drive(1, 12, 32'h55, 0, 0, 0, a0, a1);
    @(posedge clk); #2;
    bus.wb0_vld = 0;
    chk("pre_rst_RegWrite", RegWrite, 1);
    chk("pre_rst_WriteRegister", WriteRegister, 12);
    mon_en = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_RegWrite", RegWrite, 0);
    chk("mid_rst_fwd_vld", fwd_vld, 0);
    chk("mid_rst_WriteData", WriteData, 0);
    exp_q.delete();
    losses = 0;
    exp_rf[12] = old12;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1; mon_en = 1;
    drive(0, 0, 0, 0, 0, 0, a0, a1);
    drive(1, 6, 32'hCAFE, 1, 8, 32'hF00D, a0, a1);
    drive(0, 0, 0, 1, 8, 32'hF00D, a0, a1);
    repeat (3) drive(0, 0, 0, 0, 0, 0, a0, a1);

    chk("queue_drained", 64'(exp_q.size()), 0);
    for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), rf[i], exp_rf[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the two-read/one-write register file. It shares the file's single write port between the in-order pipeline write-back (port 0) and the long-latency unit write-back (port 1, e.g. load/mul/div). Fixed priority goes to port 0, with a starvation guard for port 1. The write-port drive is registered, and writes to x0 are filtered. A forwarding copy of the in-flight write lets decode bypass the register file for the cycle it is being written.

## Interface

Parameters:
- STARVE_LIMIT, 3: consecutive port-1 losses before port 1 is forced to win; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- wb0_vld  in  1  port 0 (pipeline) write request.
- wb0_rd  in  5  port 0 destination register.
- wb0_data  in  32  port 0 write data.
- wb0_rdy  out  1  port 0 accepted this cycle.
- wb1_vld  in  1  port 1 (long-latency unit) write request.
- wb1_rd  in  5  port 1 destination register.
- wb1_data  in  32  port 1 write data.
- wb1_rdy  out  1  port 1 accepted this cycle.
- RegWrite  out  1  register-file write enable; registered.
- WriteRegister  out  5  register-file write address; registered.
- WriteData  out  32  register-file write data; registered.
- fwd_vld  out  1  equals RegWrite; marks the in-flight write for bypass.
- fwd_rd  out  5  equals WriteRegister.
- fwd_data  out  32  equals WriteData.

## Operation

- Handshake: a transfer occurs when vld && rdy in the same cycle. A requester holds vld/rd/data stable until accepted. rdy is combinational from the current vld/rd and starvation state.
- x0 filter:
  - A valid request with rd==0 is accepted (rdy=1) in the cycle it is presented, regardless of the other port.
  - It produces no RegWrite and does not take part in arbitration.
  - Both ports presenting rd==0 are both accepted.
- Arbitration applies only among valid requests with rd!=0:
  - If only one port requests, it wins.
  - If both request, port 0 wins, unless starve_cnt == STARVE_LIMIT, in which case port 1 wins.
  - Exactly one nonzero-rd request is accepted per cycle.
- Starvation counter starve_cnt, 4 bits:
  - Increments when port 1 has a valid nonzero-rd request and port 0 wins.
  - Clears to 0 when port 1 is accepted or wb1_vld is low.
  - Saturates at STARVE_LIMIT.
- Output stage: on acceptance of a nonzero-rd request, the next posedge loads RegWrite=1, WriteRegister=rd, WriteData=data. If no nonzero-rd acceptance occurs, RegWrite=0 next cycle and WriteRegister/WriteData hold their values.
- Same-register collision: both ports targeting the same rd are serialized in arbitration order and never merged. The later write determines the final value.
- The arbiter never back-pressures the register file; there is no buffering beyond the output register.

## Timing

- Reset (rst_n low, asynchronous): RegWrite=0, WriteRegister=0, WriteData=0, starve_cnt=0, fwd_* = 0. wb0_rdy and wb1_rdy are 0 while rst_n is low.
- Accept-to-RegWrite latency is 1 cycle. The register file commits at the following posedge, 2 edges after the accept edge.
- RegWrite is high for exactly one cycle per accepted nonzero-rd request.
- Back-to-back accepts give continuous RegWrite=1 with a new address each cycle; throughput is 1 write per cycle.
- Forwarding: fwd_* is valid in the same cycle as RegWrite. Decode must prefer fwd_data when fwd_vld && fwd_rd == read address && address != 0, because the register file returns the old value in that cycle.
- Reset mid-operation: asserting rst_n drops RegWrite immediately, so a pending write is lost. Requesters re-present after reset.
- Worst-case port-1 wait under continuous port-0 traffic is STARVE_LIMIT cycles; port 1 is accepted in the (STARVE_LIMIT+1)th cycle.

## Test plan

- Reset: hold rst_n=0 with both vld=1 -> RegWrite=0, WriteRegister=0, WriteData=0, wb0_rdy=wb1_rdy=0; release -> arbitration starts the next cycle.
- Single write: wb0_vld=1, rd=5, data=0xDEADBEEF for one cycle -> wb0_rdy=1 that cycle; next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF for one cycle; register-file read of x5 afterwards returns 0xDEADBEEF.
- Starvation: STARVE_LIMIT=3, both ports continuously valid with rd=1 (port 0) and rd=2 (port 1) -> accept order 0,0,0,1,0,0,0,1; WriteRegister sequence 1,1,1,2 repeating.
- x0 filter: wb0 rd=7 data=0x11 and wb1 rd=0 data=0x22 in the same cycle -> both rdy=1 that cycle; exactly one RegWrite pulse, to x7 with 0x11; x0 still reads 0.
- Collision: wb0 rd=9 data=1 and wb1 rd=9 data=2 in the same cycle -> port 0 accepted first, port 1 the next cycle; RegWrite pulses write 1 then 2; final x9=2; fwd_* matches each pulse.
- Reset mid-write: drop rst_n asynchronously while RegWrite=1 for rd=12 data=0x55 -> RegWrite falls before the next posedge; x12 is unchanged.
